// File: rtl/audio_output_scheduler.sv
// rtl/audio_output_scheduler.sv - shares the codec DAC sample port between drum/synth/demo producers
// Mode changes insert a fixed run of zero-sample slots before the new source is played.
module audio_output_scheduler #(
    parameter int DATA_W       = 24,
    parameter int MUTE_SAMPLES = 256,
    parameter int UND_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              menu,
    input  logic              drum,
    input  logic              synth,
    input  logic              demo,
    input  logic              drum_valid,
    input  logic [DATA_W-1:0] drum_data,
    output logic              drum_pop,
    input  logic              synth_valid,
    input  logic [DATA_W-1:0] synth_data,
    output logic              synth_pop,
    input  logic              demo_valid,
    input  logic [DATA_W-1:0] demo_data,
    output logic              demo_pop,
    input  logic              dac_req,
    output logic              dac_write,
    output logic [DATA_W-1:0] dac_data,
    output logic [1:0]        active_src,
    output logic              muting,
    output logic [UND_W-1:0]  underruns
);

    localparam int CNT_W = (MUTE_SAMPLES > 1) ? $clog2(MUTE_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] MUTE_LAST = CNT_W'(MUTE_SAMPLES - 1);

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_DRUM  = 2'd1;
    localparam logic [1:0] SRC_SYNTH = 2'd2;
    localparam logic [1:0] SRC_DEMO  = 2'd3;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_MUTE   = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cur_src;
    logic [CNT_W-1:0]   r_mute_cnt;
    logic               r_dac_write;
    logic [DATA_W-1:0]  r_dac_data;
    logic [UND_W-1:0]   r_underruns;

    logic [1:0]         w_sel_src;
    logic               w_change;
    logic               w_src_valid;
    logic [DATA_W-1:0]  w_src_data;
    logic               w_play_req;

    // Menu, no mode, or an ambiguous multi-mode selection all park the output on NONE.
    always_comb begin
        w_sel_src = SRC_NONE;
        if (!menu) begin
            case ({demo, synth, drum})
                3'b001:  w_sel_src = SRC_DRUM;
                3'b010:  w_sel_src = SRC_SYNTH;
                3'b100:  w_sel_src = SRC_DEMO;
                default: w_sel_src = SRC_NONE;
            endcase
        end
    end

    always_comb begin
        w_src_valid = 1'b0;
        w_src_data  = '0;
        case (r_cur_src)
            SRC_DRUM:  begin w_src_valid = drum_valid;  w_src_data = drum_data;  end
            SRC_SYNTH: begin w_src_valid = synth_valid; w_src_data = synth_data; end
            SRC_DEMO:  begin w_src_valid = demo_valid;  w_src_data = demo_data;  end
            default:   begin w_src_valid = 1'b0;        w_src_data = '0;         end
        endcase
    end

    assign w_change   = (w_sel_src != r_cur_src);
    assign w_play_req = dac_req && (r_state == ST_PLAY) && !w_change;

    assign drum_pop   = w_play_req && (r_cur_src == SRC_DRUM)  && drum_valid;
    assign synth_pop  = w_play_req && (r_cur_src == SRC_SYNTH) && synth_valid;
    assign demo_pop   = w_play_req && (r_cur_src == SRC_DEMO)  && demo_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_SILENT;
            r_cur_src   <= SRC_NONE;
            r_mute_cnt  <= '0;
            r_dac_write <= 1'b0;
            r_dac_data  <= '0;
            r_underruns <= '0;
        end else begin
            r_dac_write <= dac_req;
            if (w_change) begin
                // The slot coinciding with a change is served silent and is not a mute slot.
                r_cur_src  <= w_sel_src;
                r_mute_cnt <= '0;
                r_state    <= ST_MUTE;
                if (dac_req) r_dac_data <= '0;
            end else if (dac_req) begin
                case (r_state)
                    ST_SILENT: r_dac_data <= '0;
                    ST_MUTE: begin
                        r_dac_data <= '0;
                        if (r_mute_cnt == MUTE_LAST) begin
                            r_mute_cnt <= '0;
                            r_state    <= (r_cur_src != SRC_NONE) ? ST_PLAY : ST_SILENT;
                        end else begin
                            r_mute_cnt <= r_mute_cnt + 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (w_src_valid) begin
                            r_dac_data <= w_src_data;
                        end else begin
                            r_dac_data <= '0;
                            if (r_underruns != {UND_W{1'b1}}) r_underruns <= r_underruns + 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_SILENT;
                        r_dac_data <= '0;
                    end
                endcase
            end
        end
    end

    assign dac_write  = r_dac_write;
    assign dac_data   = r_dac_data;
    assign active_src = r_cur_src;
    assign muting     = (r_state == ST_MUTE);
    assign underruns  = r_underruns;

endmodule

// File: tb/tb_audio_output_scheduler.sv
// tb/tb_audio_output_scheduler.sv - self-checking bench for audio_output_scheduler
`timescale 1ns/100ps
module tb_audio_output_scheduler;

    localparam int DW = 24;
    localparam int MS = 4;
    localparam int UW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          menu = 1'b0, drum = 1'b0, synth = 1'b0, demo = 1'b0;
    logic          drum_valid = 1'b0, synth_valid = 1'b0, demo_valid = 1'b0;
    logic [DW-1:0] drum_data = '0, synth_data = '0, demo_data = '0;
    logic          drum_pop, synth_pop, demo_pop;
    logic          dac_req = 1'b0;
    logic          dac_write;
    logic [DW-1:0] dac_data;
    logic [1:0]    active_src;
    logic          muting;
    logic [UW-1:0] underruns;

    int            n_checks = 0;
    int            n_fail = 0;

    // Reference model: source, remaining mute slots, underrun tally, last sample sent.
    int            m_src;
    int            m_mute_left;
    int            m_und;
    logic [DW-1:0] m_data;
    logic          m_write;
    logic [2:0]    exp_pop;
    logic [2:0]    obs_pop;

    audio_output_scheduler #(.DATA_W(DW), .MUTE_SAMPLES(MS), .UND_W(UW)) dut (
        .clk(clk), .rst(rst),
        .menu(menu), .drum(drum), .synth(synth), .demo(demo),
        .drum_valid(drum_valid), .drum_data(drum_data), .drum_pop(drum_pop),
        .synth_valid(synth_valid), .synth_data(synth_data), .synth_pop(synth_pop),
        .demo_valid(demo_valid), .demo_data(demo_data), .demo_pop(demo_pop),
        .dac_req(dac_req), .dac_write(dac_write), .dac_data(dac_data),
        .active_src(active_src), .muting(muting), .underruns(underruns)
    );

    always #5 clk = ~clk;

    function automatic int model_sel();
        int n;
        n = int'(drum) + int'(synth) + int'(demo);
        if (menu || n != 1) return 0;
        if (drum) return 1;
        if (synth) return 2;
        return 3;
    endfunction

    function automatic logic src_valid(input int s);
        if (s == 1) return drum_valid;
        if (s == 2) return synth_valid;
        if (s == 3) return demo_valid;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] src_data(input int s);
        if (s == 1) return drum_data;
        if (s == 2) return synth_data;
        if (s == 3) return demo_data;
        return '0;
    endfunction

    task automatic model_reset();
        m_src = 0; m_mute_left = 0; m_und = 0; m_data = '0; m_write = 1'b0;
    endtask

    // One clock cycle: drive dac_req, capture the combinational pops, advance the model.
    task automatic tick(input logic req);
        int   sel;
        logic chg;
        dac_req = req;
        #1;
        sel = model_sel();
        chg = (sel != m_src);
        exp_pop = 3'b000;
        obs_pop = {demo_pop, synth_pop, drum_pop};
        m_write = req && rst;
        if (!rst) begin
            model_reset();
        end else if (chg) begin
            m_src = sel;
            m_mute_left = MS;
            if (req) m_data = '0;
        end else if (req) begin
            if (m_mute_left > 0) begin
                m_data = '0;
                m_mute_left--;
            end else if (m_src == 0) begin
                m_data = '0;
            end else if (src_valid(m_src)) begin
                m_data = src_data(m_src);
                exp_pop[m_src-1] = 1'b1;
            end else begin
                m_data = '0;
                if (m_und < 255) m_und++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(i[0]);
            n_checks++; if ({dac_write, muting, active_src, underruns, dac_data} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h required 0", {dac_write, muting, active_src, underruns, dac_data}); end
            n_checks++; if (obs_pop !== 3'b000) begin n_fail++; $display("FAIL reset_pops: got %b required 000", obs_pop); end
        end
        rst = 1'b1;
        menu = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            n_checks++; if (dac_write !== 1'b1) begin n_fail++; $display("FAIL silent_write: got %b required 1", dac_write); end
            n_checks++; if (dac_data !== '0) begin n_fail++; $display("FAIL silent_data: got %h required 0", dac_data); end
            n_checks++; if (active_src !== 2'd0 || obs_pop !== 3'b000) begin n_fail++; $display("FAIL silent_src_pops: got %0d/%b required 0/000", active_src, obs_pop); end
        end
    endtask

    task automatic test_drum_play();
        menu = 1'b0; drum = 1'b1; drum_valid = 1'b1; drum_data = 24'h000123;
        tick(1'b0);
        n_checks++; if (muting !== 1'b1 || active_src !== 2'd1) begin n_fail++; $display("FAIL drum_enter_mute: got muting=%b src=%0d required 1/1", muting, active_src); end
        for (int i = 0; i < MS; i++) begin
            tick(1'b1);
            n_checks++; if (dac_write !== 1'b1 || dac_data !== '0) begin n_fail++; $display("FAIL drum_mute_slot: got %b/%h required 1/0", dac_write, dac_data); end
            n_checks++; if (muting !== (m_mute_left > 0) || obs_pop !== 3'b000) begin n_fail++; $display("FAIL drum_mute_flag: got %b/%b required %b/000", muting, obs_pop, m_mute_left > 0); end
        end
        tick(1'b1);
        n_checks++; if (dac_data !== 24'h000123 || obs_pop !== 3'b001) begin n_fail++; $display("FAIL drum_first_sample: got %h/%b required 000123/001", dac_data, obs_pop); end
        for (int i = 0; i < 4; i++) begin
            drum_data = DW'($urandom);
            tick(1'b1);
            n_checks++; if (dac_data !== m_data || obs_pop !== exp_pop || active_src !== 2'd1) begin n_fail++; $display("FAIL drum_play: got %h/%b/%0d required %h/%b/1", dac_data, obs_pop, active_src, m_data, exp_pop); end
        end
    endtask

    task automatic test_switch_same_cycle();
        drum = 1'b0; synth = 1'b1; synth_valid = 1'b1; synth_data = DW'($urandom);
        tick(1'b1);
        n_checks++; if (dac_write !== 1'b1 || dac_data !== '0 || obs_pop !== 3'b000) begin n_fail++; $display("FAIL switch_slot: got %b/%h/%b required 1/0/000", dac_write, dac_data, obs_pop); end
        n_checks++; if (muting !== 1'b1 || active_src !== 2'd2) begin n_fail++; $display("FAIL switch_state: got %b/%0d required 1/2", muting, active_src); end
        for (int i = 0; i < MS + 4; i++) begin
            synth_data = DW'($urandom);
            tick(1'b1);
            n_checks++; if (dac_data !== m_data || obs_pop !== exp_pop || obs_pop[0] !== 1'b0) begin n_fail++; $display("FAIL switch_follow: got %h/%b required %h/%b", dac_data, obs_pop, m_data, exp_pop); end
        end
        n_checks++; if (dac_data !== synth_data) begin n_fail++; $display("FAIL switch_synth_data: got %h required %h", dac_data, synth_data); end
    endtask

    task automatic test_underrun();
        synth_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1);
            n_checks++; if (dac_write !== 1'b1 || dac_data !== '0 || underruns !== UW'(m_und)) begin n_fail++; $display("FAIL underrun_slot: got %b/%h/%0d required 1/0/%0d", dac_write, dac_data, underruns, m_und); end
        end
        n_checks++; if (underruns !== 8'd255) begin n_fail++; $display("FAIL underrun_saturate: got %0d required 255", underruns); end
    endtask

    task automatic test_none();
        drum = 1'b1; synth = 1'b1; drum_valid = 1'b1; synth_valid = 1'b1;
        tick(1'b0);
        n_checks++; if (active_src !== 2'd0 || muting !== 1'b1) begin n_fail++; $display("FAIL none_enter: got %0d/%b required 0/1", active_src, muting); end
        for (int i = 0; i < MS + 4; i++) begin
            tick(1'b1);
            n_checks++; if (dac_data !== '0 || obs_pop !== 3'b000 || muting !== (i < MS - 1)) begin n_fail++; $display("FAIL none_slot: got %h/%b/%b required 0/000/%b", dac_data, obs_pop, muting, i < MS - 1); end
        end
        synth = 1'b0;
        for (int i = 0; i < MS + 2; i++) tick(1'b1);
        menu = 1'b1;
        tick(1'b1);
        n_checks++; if (dac_data !== '0 || obs_pop !== 3'b000 || active_src !== 2'd0 || muting !== 1'b1) begin n_fail++; $display("FAIL menu_switch: got %h/%b/%0d/%b required 0/000/0/1", dac_data, obs_pop, active_src, muting); end
        for (int i = 0; i < MS + 3; i++) begin
            tick(1'b1);
            n_checks++; if (dac_data !== '0 || obs_pop !== 3'b000) begin n_fail++; $display("FAIL menu_silent: got %h/%b required 0/000", dac_data, obs_pop); end
        end
        n_checks++; if (muting !== 1'b0) begin n_fail++; $display("FAIL menu_unmute: got %b required 0", muting); end
    endtask

    task automatic test_back_to_back();
        menu = 1'b0; drum = 1'b0; synth = 1'b0; demo = 1'b1; demo_valid = 1'b1;
        for (int i = 0; i < MS + 12; i++) begin
            demo_data = DW'($urandom);
            demo_valid = (i % 5 != 3);
            tick(1'b1);
            n_checks++; if (dac_write !== 1'b1 || dac_data !== m_data || obs_pop !== exp_pop || underruns !== UW'(m_und)) begin n_fail++; $display("FAIL back_to_back: got %b/%h/%b/%0d required 1/%h/%b/%0d", dac_write, dac_data, obs_pop, underruns, m_data, exp_pop, m_und); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    {menu, drum, synth, demo} = 4'b0000;
                    case ($urandom_range(0, 2))
                        0: drum = 1'b1;
                        1: synth = 1'b1;
                        default: demo = 1'b1;
                    endcase
                end else begin
                    {menu, drum, synth, demo} = 4'($urandom);
                end
            end
            drum_valid  = ($urandom_range(0, 4) != 0);
            synth_valid = ($urandom_range(0, 4) != 0);
            demo_valid  = ($urandom_range(0, 4) != 0);
            drum_data = DW'($urandom); synth_data = DW'($urandom); demo_data = DW'($urandom);
            tick($urandom_range(0, 2) != 0);
            n_checks++; if (dac_write !== m_write || dac_data !== m_data) begin n_fail++; $display("FAIL rand_write: cycle %0d got %b/%h required %b/%h", i, dac_write, dac_data, m_write, m_data); end
            n_checks++; if (obs_pop !== exp_pop) begin n_fail++; $display("FAIL rand_pops: cycle %0d got %b required %b", i, obs_pop, exp_pop); end
            n_checks++; if (active_src !== 2'(m_src) || muting !== (m_mute_left > 0) || underruns !== UW'(m_und)) begin n_fail++; $display("FAIL rand_state: cycle %0d got %0d/%b/%0d required %0d/%b/%0d", i, active_src, muting, underruns, m_src, m_mute_left > 0, m_und); end
        end
    endtask

    task automatic test_reset_midplay();
        {menu, drum, synth, demo} = 4'b0100;
        drum_valid = 1'b1;
        for (int i = 0; i < MS + 3; i++) tick(1'b1);
        n_checks++; if (active_src !== 2'd1 || muting !== 1'b0) begin n_fail++; $display("FAIL midplay_setup: got %0d/%b required 1/0", active_src, muting); end
        dac_req = 1'b1;
        @(posedge clk);
        #0.5 rst = 1'b0;
        #0.5;
        dac_req = 1'b0;
        model_reset();
        n_checks++; if (dac_write !== 1'b0) begin n_fail++; $display("FAIL midplay_no_write: got %b required 0", dac_write); end
        n_checks++; if ({muting, active_src, underruns, dac_data} !== '0 || {demo_pop, synth_pop, drum_pop} !== 3'b000) begin n_fail++; $display("FAIL midplay_reset_vals: got %0h required 0", {muting, active_src, underruns, dac_data}); end
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1'b1);
        n_checks++; if (dac_write !== 1'b1 || dac_data !== '0 || muting !== 1'b1 || active_src !== 2'd1) begin n_fail++; $display("FAIL midplay_resume: got %b/%h/%b/%0d required 1/0/1/1", dac_write, dac_data, muting, active_src); end
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_drum_play();
        test_switch_same_cycle();
        test_underrun();
        test_none();
        test_back_to_back();
        test_random();
        test_reset_midplay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
